mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter SRAM_DW, default 16, SRAM data width in bits; legal values 16 or 32.
REQ-002 SHALL have parameter ADDR_W, default 20, SRAM word-address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 0, extra wait states per SRAM beat; legal range 0..3.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-005 SHALL have port i_clk, input, 1: clock, rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port i_req, input, 1: access request; sampled only when o_ready=1.
REQ-008 SHALL have port i_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port i_funct3, input, 3: RV32I load/store width code.
REQ-010 SHALL have port i_addr, input, 32: byte address.
REQ-011 SHALL have port i_write_data, input, 32: store data.
REQ-012 SHALL have port o_ready, output, 1: idle and able to accept a request.
REQ-013 SHALL have port o_bubble, output, 1: pipeline stall request; 1 from the accept cycle through the cycle before o_done.
REQ-014 SHALL have port o_done, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port o_fault, output, 1: qualifies o_done; misaligned address or illegal funct3.
REQ-016 SHALL have port o_read_data, output, 32: extended load result.
REQ-017 SHALL have port o_sram_addr, output, ADDR_W: SRAM word address.
REQ-018 SHALL have port o_sram_wdata, output, SRAM_DW: SRAM write data.
REQ-019 SHALL have port i_sram_rdata, input, SRAM_DW: SRAM read data.
REQ-020 SHALL have ports o_sram_ce_n, o_sram_oe_n and o_sram_we_n, output, 1 each: SRAM strobes, active-low.
REQ-021 SHALL have port o_sram_be_n, output, SRAM_DW/8: byte-lane enables, active-low.

Function
REQ-022 SHALL latch i_we, i_funct3, i_addr and i_write_data when i_req=1 and o_ready=1 (accept cycle); i_req while busy SHALL be ignored.
REQ-023 SHALL implement FSM IDLE -> BEAT -> (WAIT, if WAIT_CYCLES>0) -> BEAT for the next beat, or DONE -> IDLE.
REQ-024 SHALL hold each beat for 1+WAIT_CYCLES cycles with ce_n=0; for a load, oe_n=0 and capture on the beat's last cycle; for a store, we_n=0 on every cycle of the beat except the last.
REQ-025 SHALL use 1 beat for byte and half accesses; words SHALL use SRAM_DW=16: 2 beats (low half at even word address first) and SRAM_DW=32: 1 beat.
REQ-026 SHALL compute o_sram_addr = i_addr >> log2(SRAM_DW/8), plus beat index; byte order is little-endian, with the lowest byte address in lane [7:0].
REQ-027 SHALL assert only the addressed lanes in o_sram_be_n (SB: 1 lane, SH: 2 lanes, SW: all lanes of the beat) and replicate store data onto the selected lanes.
REQ-028 SHALL produce loads as follows: LB/LH sign-extend, LBU/LHU zero-extend, LW assembles the beats; o_read_data SHALL update only in the DONE cycle.
REQ-029 SHALL pulse o_done for exactly 1 cycle in the DONE state; o_ready SHALL be 1 only in IDLE.
REQ-030 SHALL treat the following as faults, completing with o_done=o_fault=1 one cycle after accept, with no SRAM strobe and o_read_data unchanged: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 > 010.
REQ-031 SHALL complete a non-fault access in 1 + beats*(1+WAIT_CYCLES) cycles, measured from the accept edge to the o_done cycle.
REQ-032 SHALL keep SRAM strobes and be_n deasserted (all 1) whenever not in BEAT/WAIT.

Reset
REQ-033 SHALL, on i_rst=1 and asynchronously even mid-access, set state=IDLE, o_ready=1, o_bubble=0, o_done=0, o_fault=0, o_read_data=0, o_sram_addr=0, o_sram_wdata=0 and all strobes and be_n to 1; an aborted store SHALL not complete.

Structure
REQ-034 SHALL place the funct3 codes, the FSM state encoding and the fault-decode constants in shared package mem_access_pkg.
REQ-035 SHALL use one sub-module, mem_lane_align (combinational), for lane select, store replication and load extension.

Verification
REQ-036 SHALL test SRAM_DW=16, WAIT=0, LB at addr 0x3, with rdata=0x80AA: result 0xFFFFFF80, be_n=01, o_done on cycle 2.
REQ-037 SHALL test SRAM_DW=16, WAIT=2, SW 0x12345678 at 0x10: beats write 0x5678 then 0x1234 at word addrs 8 and 9, o_done on cycle 7.
REQ-038 SHALL test LW at 0x6 -> o_done=o_fault=1 on cycle 1, no ce_n low, o_read_data unchanged.
REQ-039 SHALL test SRAM_DW=32, LHU at 0x2, with rdata=0xBEEF0000: result 0x0000BEEF, be_n=0011.
REQ-040 SHALL test i_rst asserted during beat 2 of an SW: all strobes high immediately, o_ready=1, and no o_done.
REQ-041 SHALL test i_req held high during a busy access: exactly one o_done, with the second request accepted only in IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the SRAM load/store unit: RV32I width codes,
// FSM encoding and the misalignment/illegal-code fault decode.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] STORE_F3_MAX    = F3_W;
  localparam logic [1:0] HALF_ALIGN_MASK = 2'b01;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BEAT = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // 1 when the request must complete as a fault without touching the SRAM
  function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                        input logic [1:0] addr_lo);
    logic f;
    if (we) f = (f3 > STORE_F3_MAX);
    else    f = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if ((f3 == F3_H) || (f3 == F3_HU)) f = f | (|(addr_lo & HALF_ALIGN_MASK));
    if (f3 == F3_W)                    f = f | (|(addr_lo & WORD_ALIGN_MASK));
    return f;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Core-side request/response and SRAM pins of the memory access unit.
interface mem_access_unit_if #(
  parameter int unsigned SRAM_DW = 16,
  parameter int unsigned ADDR_W  = 20
);
  localparam int unsigned LANES = SRAM_DW / 8;

  logic              i_req;
  logic              i_we;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr;
  logic [31:0]       i_write_data;
  logic              o_ready;
  logic              o_bubble;
  logic              o_done;
  logic              o_fault;
  logic [31:0]       o_read_data;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [SRAM_DW-1:0] o_sram_wdata;
  logic [SRAM_DW-1:0] i_sram_rdata;
  logic              o_sram_ce_n;
  logic              o_sram_oe_n;
  logic              o_sram_we_n;
  logic [LANES-1:0]  o_sram_be_n;

  modport slave (
    input  i_req, i_we, i_funct3, i_addr, i_write_data, i_sram_rdata,
    output o_ready, o_bubble, o_done, o_fault, o_read_data,
           o_sram_addr, o_sram_wdata, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_be_n
  );

  modport master (
    output i_req, i_we, i_funct3, i_addr, i_write_data, i_sram_rdata,
    input  o_ready, o_bubble, o_done, o_fault, o_read_data,
           o_sram_addr, o_sram_wdata, o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_be_n
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte-enable select, store replication and
// load shift/extension for one SRAM word.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int unsigned SRAM_DW = 16
) (
  input  logic [2:0]           funct3_i,
  input  logic [1:0]           offset_i,
  input  logic                 beat_i,
  input  logic [31:0]          store_data_i,
  input  logic [31:0]          raw_load_i,
  output logic [SRAM_DW/8-1:0] be_n_o,
  output logic [SRAM_DW-1:0]   wdata_o,
  output logic [31:0]          load_data_o
);
  localparam int unsigned LANES = SRAM_DW / 8;

  logic [31:0] shifted;

  always_comb begin
    be_n_o  = '0;
    wdata_o = SRAM_DW'(beat_i ? (store_data_i >> 16) : store_data_i);
    case (funct3_i)
      F3_B, F3_BU: begin
        be_n_o  = ~(LANES'(1) << offset_i);
        wdata_o = {LANES{store_data_i[7:0]}};
      end
      F3_H, F3_HU: begin
        be_n_o  = ~(LANES'(3) << offset_i);
        wdata_o = {(LANES / 2){store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Lowest byte address sits in lane [7:0], so shifting by the offset aligns the datum
  always_comb begin
    shifted     = raw_load_i >> {offset_i, 3'b000};
    load_data_o = shifted;
    case (funct3_i)
      F3_B:  load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU: load_data_o = {24'h0, shifted[7:0]};
      F3_H:  load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU: load_data_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store sequencer for an asynchronous 16- or 32-bit SRAM with
// programmable wait states; words on a 16-bit SRAM take two beats.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned SRAM_DW     = 16,
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_access_unit_if.slave   bus
);
  localparam int unsigned LANES    = SRAM_DW / 8;
  localparam int unsigned SHIFT    = (SRAM_DW == 32) ? 2 : 1;
  localparam logic [1:0]  OFF_MASK = (SRAM_DW == 32) ? 2'b11 : 2'b01;
  localparam logic [1:0]  LAST_CNT = 2'(WAIT_CYCLES);
  localparam logic        HAS_WAIT = (WAIT_CYCLES != 0);

  state_e             state_q;
  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         addr_lo_q;
  logic [31:0]        wdata_in_q;
  logic               beat_q;
  logic [1:0]         cnt_q;
  logic [15:0]        lo_q;
  logic               ready_q, done_q, fault_q;
  logic [31:0]        rdata_q;
  logic [ADDR_W-1:0]  sram_addr_q;
  logic [SRAM_DW-1:0] sram_wdata_q;
  logic               ce_n_q, oe_n_q, we_n_q;
  logic [LANES-1:0]   be_n_q;

  logic               idle;
  logic               two_beat;
  logic [2:0]         al_funct3;
  logic [1:0]         al_off;
  logic [31:0]        al_store;
  logic [31:0]        raw_load;
  logic [31:0]        load_data;
  logic [LANES-1:0]   al_be_n;
  logic [SRAM_DW-1:0] al_wdata;
  logic               unused_bits;

  assign idle      = (state_q == S_IDLE);
  assign two_beat  = (SRAM_DW == 16) && (funct3_q == F3_W);
  // In IDLE the aligner sees the incoming request so beat 0 can be registered on accept
  assign al_funct3 = idle ? bus.i_funct3 : funct3_q;
  assign al_off    = (idle ? bus.i_addr[1:0] : addr_lo_q) & OFF_MASK;
  assign al_store  = idle ? bus.i_write_data : wdata_in_q;

  generate
    if (SRAM_DW == 16) begin : g_raw16
      assign raw_load = (funct3_q == F3_W) ? {16'(bus.i_sram_rdata), lo_q}
                                           : 32'(bus.i_sram_rdata);
    end else begin : g_raw32
      assign raw_load = 32'(bus.i_sram_rdata);
    end
  endgenerate

  mem_lane_align #(.SRAM_DW(SRAM_DW)) u_align (
    .funct3_i     (al_funct3),
    .offset_i     (al_off),
    .beat_i       (!idle),
    .store_data_i (al_store),
    .raw_load_i   (raw_load),
    .be_n_o       (al_be_n),
    .wdata_o      (al_wdata),
    .load_data_o  (load_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      addr_lo_q    <= '0;
      wdata_in_q   <= '0;
      beat_q       <= 1'b0;
      cnt_q        <= '0;
      lo_q         <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
    end else begin
      case (state_q)
        S_IDLE: if (bus.i_req) begin
          we_q       <= bus.i_we;
          funct3_q   <= bus.i_funct3;
          addr_lo_q  <= bus.i_addr[1:0];
          wdata_in_q <= bus.i_write_data;
          beat_q     <= 1'b0;
          cnt_q      <= '0;
          ready_q    <= 1'b0;
          if (access_fault(bus.i_we, bus.i_funct3, bus.i_addr[1:0])) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            fault_q <= 1'b1;
          end else begin
            state_q      <= S_BEAT;
            ce_n_q       <= 1'b0;
            oe_n_q       <= bus.i_we;
            we_n_q       <= ~(bus.i_we & HAS_WAIT);
            be_n_q       <= al_be_n;
            sram_addr_q  <= ADDR_W'(bus.i_addr >> SHIFT);
            sram_wdata_q <= al_wdata;
          end
        end
        S_BEAT, S_WAIT: begin
          if (cnt_q != LAST_CNT) begin
            // Write strobe drops on the final cycle of the beat
            state_q <= S_WAIT;
            cnt_q   <= cnt_q + 2'd1;
            we_n_q  <= ~(we_q & ((cnt_q + 2'd1) != LAST_CNT));
          end else if (two_beat && !beat_q) begin
            state_q      <= S_BEAT;
            beat_q       <= 1'b1;
            cnt_q        <= '0;
            lo_q         <= 16'(bus.i_sram_rdata);
            sram_addr_q  <= sram_addr_q + ADDR_W'(1);
            sram_wdata_q <= al_wdata;
            we_n_q       <= ~(we_q & HAS_WAIT);
          end else begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= '1;
            if (!we_q) rdata_q <= load_data;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ready      = ready_q;
  assign bus.o_bubble     = (idle & bus.i_req) | (state_q == S_BEAT) | (state_q == S_WAIT);
  assign bus.o_done       = done_q;
  assign bus.o_fault      = fault_q;
  assign bus.o_read_data  = rdata_q;
  assign bus.o_sram_addr  = sram_addr_q;
  assign bus.o_sram_wdata = sram_wdata_q;
  assign bus.o_sram_ce_n  = ce_n_q;
  assign bus.o_sram_oe_n  = oe_n_q;
  assign bus.o_sram_we_n  = we_n_q;
  assign bus.o_sram_be_n  = be_n_q;

  assign unused_bits = ^{bus.i_addr, lo_q};

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit across 16-bit/no-wait, 16-bit/2-wait
// and 32-bit/no-wait configurations sharing one clock and reset.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_access_unit_if #(.SRAM_DW(16), .ADDR_W(20)) b0 ();
  mem_access_unit_if #(.SRAM_DW(16), .ADDR_W(20)) b2 ();
  mem_access_unit_if #(.SRAM_DW(32), .ADDR_W(20)) b3 ();

  mem_access_unit #(.SRAM_DW(16), .ADDR_W(20), .WAIT_CYCLES(0)) u_w0 (.i_clk(clk), .i_rst(rst), .bus(b0));
  mem_access_unit #(.SRAM_DW(16), .ADDR_W(20), .WAIT_CYCLES(2)) u_w2 (.i_clk(clk), .i_rst(rst), .bus(b2));
  mem_access_unit #(.SRAM_DW(32), .ADDR_W(20), .WAIT_CYCLES(0)) u_32 (.i_clk(clk), .i_rst(rst), .bus(b3));

  logic [15:0] mem16 [16];
  logic [31:0] mem32 [16];

  assign b0.i_sram_rdata = mem16[b0.o_sram_addr[3:0]];
  assign b2.i_sram_rdata = mem16[b2.o_sram_addr[3:0]];
  assign b3.i_sram_rdata = mem32[b3.o_sram_addr[3:0]];

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b0.o_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b want 1", b0.o_ready); end
    checks++; if (b0.o_bubble !== 1'b0) begin failures++; $display("FAIL rst_bubble: got %b want 0", b0.o_bubble); end
    checks++; if (b0.o_done !== 1'b0 || b0.o_fault !== 1'b0) begin failures++; $display("FAIL rst_done_fault: got %b%b want 00", b0.o_done, b0.o_fault); end
    checks++; if (b0.o_read_data !== 32'h0) begin failures++; $display("FAIL rst_rdata: got %h want 0", b0.o_read_data); end
    checks++; if (b0.o_sram_addr !== 20'h0 || b0.o_sram_wdata !== 16'h0) begin failures++; $display("FAIL rst_addr_wdata: got %h/%h want 0/0", b0.o_sram_addr, b0.o_sram_wdata); end
    checks++; if ({b0.o_sram_ce_n, b0.o_sram_oe_n, b0.o_sram_we_n} !== 3'b111) begin failures++; $display("FAIL rst_strobes: got %b want 111", {b0.o_sram_ce_n, b0.o_sram_oe_n, b0.o_sram_we_n}); end
    checks++; if (b0.o_sram_be_n !== 2'b11 || b3.o_sram_be_n !== 4'hF) begin failures++; $display("FAIL rst_be_n: got %b/%b want 11/1111", b0.o_sram_be_n, b3.o_sram_be_n); end
    rst = 1'b0;
  endtask

  // LB at 0x3 reads the upper lane of word 1 (0x80AA) and sign-extends 0x80
  task automatic test_lb_sign();
    int done_cyc = 0;
    logic [1:0] be1 = '1;
    logic [19:0] a1 = '0;
    logic oe1 = 1'b1;
    b0.i_req = 1'b1; b0.i_we = 1'b0; b0.i_funct3 = 3'b000; b0.i_addr = 32'h3;
    #1;
    checks++; if (b0.o_bubble !== 1'b1) begin failures++; $display("FAIL lb_bubble_accept: got %b want 1", b0.o_bubble); end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin b0.i_req = 1'b0; be1 = b0.o_sram_be_n; a1 = b0.o_sram_addr; oe1 = b0.o_sram_oe_n; end
      if (b0.o_done) begin done_cyc = c; break; end
    end
    checks++; if (be1 !== 2'b01) begin failures++; $display("FAIL lb_be_n: got %b want 01", be1); end
    checks++; if (a1 !== 20'h1 || oe1 !== 1'b0) begin failures++; $display("FAIL lb_addr_oe: got %h/%b want 1/0", a1, oe1); end
    checks++; if (done_cyc != 2) begin failures++; $display("FAIL lb_done_cycle: got %0d want 2", done_cyc); end
    checks++; if (b0.o_read_data !== 32'hFFFFFF80 || b0.o_fault !== 1'b0) begin failures++; $display("FAIL lb_result: got %h fault %b want ffffff80 fault 0", b0.o_read_data, b0.o_fault); end
    checks++; if (b0.o_bubble !== 1'b0) begin failures++; $display("FAIL lb_bubble_done: got %b want 0", b0.o_bubble); end
    @(posedge clk); #1;
    checks++; if (b0.o_done !== 1'b0 || b0.o_ready !== 1'b1) begin failures++; $display("FAIL lb_after_done: got done %b ready %b want 0 1", b0.o_done, b0.o_ready); end
  endtask

  // LW at 0x8 on a 16-bit SRAM: word 4 (low) then word 5 (high)
  task automatic test_lw_two_beat();
    int done_cyc = 0;
    logic [19:0] a1 = '0, a2 = '0;
    b0.i_req = 1'b1; b0.i_we = 1'b0; b0.i_funct3 = 3'b010; b0.i_addr = 32'h8;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin b0.i_req = 1'b0; a1 = b0.o_sram_addr; end
      if (c == 2) a2 = b0.o_sram_addr;
      if (b0.o_done) begin done_cyc = c; break; end
    end
    checks++; if (a1 !== 20'h4 || a2 !== 20'h5) begin failures++; $display("FAIL lw16_addrs: got %h,%h want 4,5", a1, a2); end
    checks++; if (done_cyc != 3) begin failures++; $display("FAIL lw16_done_cycle: got %0d want 3", done_cyc); end
    checks++; if (b0.o_read_data !== 32'h1234CAFE) begin failures++; $display("FAIL lw16_result: got %h want 1234cafe", b0.o_read_data); end
    @(posedge clk); #1;
  endtask

  // SW 0x12345678 at 0x10 with two wait states: 3-cycle beats, we_n low on the first two
  task automatic test_sw_wait();
    int done_cyc = 0, we_low = 0, oe_low = 0;
    logic [19:0] ad [8];
    logic [15:0] wd [8];
    logic        ce [8];
    logic        we [8];
    logic [1:0]  be [8];
    b2.i_req = 1'b1; b2.i_we = 1'b1; b2.i_funct3 = 3'b010; b2.i_addr = 32'h10; b2.i_write_data = 32'h12345678;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) b2.i_req = 1'b0;
      if (c < 8) begin ad[c] = b2.o_sram_addr; wd[c] = b2.o_sram_wdata; ce[c] = b2.o_sram_ce_n; we[c] = b2.o_sram_we_n; be[c] = b2.o_sram_be_n; end
      if (!b2.o_sram_ce_n && !b2.o_sram_we_n) we_low++;
      if (!b2.o_sram_oe_n) oe_low++;
      if (b2.o_done) begin done_cyc = c; break; end
    end
    checks++; if (done_cyc != 7) begin failures++; $display("FAIL sw_done_cycle: got %0d want 7", done_cyc); end
    checks++; if (we_low != 4 || oe_low != 0) begin failures++; $display("FAIL sw_strobe_counts: got we %0d oe %0d want 4 0", we_low, oe_low); end
    checks++; if (ad[1] !== 20'h8 || wd[1] !== 16'h5678 || we[1] !== 1'b0 || be[1] !== 2'b00) begin failures++; $display("FAIL sw_beat0: got %h %h we %b be %b want 8 5678 0 00", ad[1], wd[1], we[1], be[1]); end
    checks++; if (ce[3] !== 1'b0 || we[3] !== 1'b1) begin failures++; $display("FAIL sw_beat0_last: got ce %b we %b want 0 1", ce[3], we[3]); end
    checks++; if (ad[4] !== 20'h9 || wd[4] !== 16'h1234 || we[4] !== 1'b0) begin failures++; $display("FAIL sw_beat1: got %h %h we %b want 9 1234 0", ad[4], wd[4], we[4]); end
    checks++; if (ce[6] !== 1'b0 || we[6] !== 1'b1 || ce[7] !== 1'b1) begin failures++; $display("FAIL sw_beat1_last: got ce6 %b we6 %b ce7 %b want 0 1 1", ce[6], we[6], ce[7]); end
    @(posedge clk); #1;
  endtask

  // Misaligned or illegal-code requests fault one cycle after accept, no SRAM activity
  task automatic test_fault();
    logic        we_v [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0]  f3_v [8] = '{3'b010, 3'b001, 3'b101, 3'b011, 3'b110, 3'b011, 3'b001, 3'b010};
    logic [31:0] ad_v [8] = '{32'h6, 32'h1, 32'h3, 32'h0, 32'h0, 32'h0, 32'h5, 32'h2};
    for (int v = 0; v < 8; v++) begin
      int done_cyc = 0, ce_low = 0;
      b0.i_req = 1'b1; b0.i_we = we_v[v]; b0.i_funct3 = f3_v[v]; b0.i_addr = ad_v[v];
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (c == 1) b0.i_req = 1'b0;
        if (!b0.o_sram_ce_n || b0.o_sram_be_n !== 2'b11) ce_low++;
        if (b0.o_done) begin done_cyc = c; break; end
      end
      checks++; if (done_cyc != 1 || b0.o_fault !== 1'b1) begin failures++; $display("FAIL fault_%0d_done: got cycle %0d fault %b want 1 1", v, done_cyc, b0.o_fault); end
      checks++; if (ce_low != 0) begin failures++; $display("FAIL fault_%0d_strobe: got %0d active cycles want 0", v, ce_low); end
      checks++; if (b0.o_read_data !== 32'h1234CAFE) begin failures++; $display("FAIL fault_%0d_rdata: got %h want 1234cafe", v, b0.o_read_data); end
      @(posedge clk); #1;
    end
  endtask

  // 32-bit SRAM: LHU at 0x2, LW at 0x8, LH at 0xC, SB 0xAB at 0x5
  task automatic test_sram32();
    logic        we_v [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_v [4] = '{3'b101, 3'b010, 3'b001, 3'b000};
    logic [31:0] ad_v [4] = '{32'h2, 32'h8, 32'hC, 32'h5};
    logic [3:0]  be_x [4] = '{4'b0011, 4'b0000, 4'b1100, 4'b1101};
    logic [19:0] wa_x [4] = '{20'h0, 20'h2, 20'h3, 20'h1};
    logic [31:0] dx_x [4] = '{32'h0000BEEF, 32'hDEADBEEF, 32'hFFFF8001, 32'hABABABAB};
    for (int v = 0; v < 4; v++) begin
      int done_cyc = 0;
      logic [3:0] be1 = '1;
      logic [19:0] a1 = '0;
      logic [31:0] w1 = '0;
      b3.i_req = 1'b1; b3.i_we = we_v[v]; b3.i_funct3 = f3_v[v]; b3.i_addr = ad_v[v]; b3.i_write_data = 32'h000000AB;
      for (int c = 1; c <= 10; c++) begin
        @(posedge clk); #1;
        if (c == 1) begin b3.i_req = 1'b0; be1 = b3.o_sram_be_n; a1 = b3.o_sram_addr; w1 = b3.o_sram_wdata; end
        if (b3.o_done) begin done_cyc = c; break; end
      end
      checks++; if (be1 !== be_x[v] || a1 !== wa_x[v]) begin failures++; $display("FAIL s32_%0d_lane: got be %b addr %h want %b %h", v, be1, a1, be_x[v], wa_x[v]); end
      checks++; if (done_cyc != 2) begin failures++; $display("FAIL s32_%0d_done_cycle: got %0d want 2", v, done_cyc); end
      if (we_v[v]) begin
        checks++; if (w1 !== dx_x[v]) begin failures++; $display("FAIL s32_%0d_wdata: got %h want %h", v, w1, dx_x[v]); end
      end else begin
        checks++; if (b3.o_read_data !== dx_x[v]) begin failures++; $display("FAIL s32_%0d_rdata: got %h want %h", v, b3.o_read_data, dx_x[v]); end
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset asserted in the first cycle of beat 2 of a waited SW
  task automatic test_reset_mid();
    int dones = 0, not_ready = 0;
    logic ce4 = 1'b1;
    logic [19:0] a4 = '0;
    b2.i_req = 1'b1; b2.i_we = 1'b1; b2.i_funct3 = 3'b010; b2.i_addr = 32'h20; b2.i_write_data = 32'hAABBCCDD;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) b2.i_req = 1'b0;
      if (b2.o_done) dones++;
    end
    ce4 = b2.o_sram_ce_n; a4 = b2.o_sram_addr;
    checks++; if (ce4 !== 1'b0 || a4 !== 20'h11) begin failures++; $display("FAIL rmid_in_beat2: got ce %b addr %h want 0 11", ce4, a4); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({b2.o_sram_ce_n, b2.o_sram_oe_n, b2.o_sram_we_n} !== 3'b111 || b2.o_sram_be_n !== 2'b11) begin failures++; $display("FAIL rmid_strobes: got %b be %b want 111 11", {b2.o_sram_ce_n, b2.o_sram_oe_n, b2.o_sram_we_n}, b2.o_sram_be_n); end
    checks++; if (b2.o_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready: got %b want 1", b2.o_ready); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (b2.o_done) dones++;
      if (!b2.o_ready) not_ready++;
    end
    checks++; if (dones != 0 || not_ready != 0) begin failures++; $display("FAIL rmid_no_done: got dones %0d busy %0d want 0 0", dones, not_ready); end
  endtask

  // i_req held while busy: the in-flight access keeps its latched fields; next is taken in IDLE
  task automatic test_back_to_back();
    int done_first = 0, done_total = 0, second_cyc = 0;
    logic rdy1 = 1'b1, rdy2 = 1'b1, rdy3 = 1'b0;
    logic [31:0] first_data = '0;
    b0.i_req = 1'b1; b0.i_we = 1'b0; b0.i_funct3 = 3'b000; b0.i_addr = 32'h3;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin b0.i_funct3 = 3'b100; b0.i_addr = 32'h2; rdy1 = b0.o_ready; end
      if (c == 2) rdy2 = b0.o_ready;
      if (c == 3) rdy3 = b0.o_ready;
      if (c == 4) b0.i_req = 1'b0;
      if (b0.o_done) begin
        done_total++;
        if (c <= 4) begin done_first++; first_data = b0.o_read_data; end
        else second_cyc = c;
      end
    end
    checks++; if (rdy1 !== 1'b0 || rdy2 !== 1'b0 || rdy3 !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b%b%b want 001", rdy1, rdy2, rdy3); end
    checks++; if (done_first != 1 || first_data !== 32'hFFFFFF80) begin failures++; $display("FAIL b2b_first: got %0d dones data %h want 1 ffffff80", done_first, first_data); end
    checks++; if (done_total != 2 || second_cyc != 5) begin failures++; $display("FAIL b2b_second: got %0d dones at %0d want 2 at 5", done_total, second_cyc); end
    checks++; if (b0.o_read_data !== 32'h000000AA) begin failures++; $display("FAIL b2b_second_data: got %h want 000000aa", b0.o_read_data); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem16[i] = 16'h0; mem32[i] = 32'h0; end
    mem16[1] = 16'h80AA; mem16[4] = 16'hCAFE; mem16[5] = 16'h1234;
    mem32[0] = 32'hBEEF0000; mem32[2] = 32'hDEADBEEF; mem32[3] = 32'h00008001;
    b0.i_req = 1'b0; b0.i_we = 1'b0; b0.i_funct3 = '0; b0.i_addr = '0; b0.i_write_data = '0;
    b2.i_req = 1'b0; b2.i_we = 1'b0; b2.i_funct3 = '0; b2.i_addr = '0; b2.i_write_data = '0;
    b3.i_req = 1'b0; b3.i_we = 1'b0; b3.i_funct3 = '0; b3.i_addr = '0; b3.i_write_data = '0;
    test_reset();
    test_lb_sign();
    test_lw_two_beat();
    test_sw_wait();
    test_fault();
    test_sram32();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
